// File: rtl/water_valve_actuator.sv
// rtl/water_valve_actuator.sv - fail-safe water valve motor sequencer with code stability filter
// Optional: define WATER_VALVE_TIMEOUT_FAULT_EN to treat stroke timeout as a fault instead of trusted travel.
module water_valve_actuator #(
  parameter int STABLE_CYCLES = 4,
  parameter int TRAVEL_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] valve_code,
  input  logic       limit_open,
  input  logic       limit_closed,
  output logic       motor_open,
  output logic       motor_close,
  output logic       valve_is_open,
  output logic       valve_is_closed,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_INIT,
    S_CLOSING,
    S_CLOSED,
    S_OPENING,
    S_OPEN,
    S_DEAD,
    S_FAULT
  } state_t;

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] TRAVEL_MAX  = 16'(TRAVEL_CYCLES);
  localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_CYCLES - 1);

`ifdef WATER_VALVE_TIMEOUT_FAULT_EN
  localparam state_t OPEN_TIMEOUT  = S_FAULT;
  localparam state_t CLOSE_TIMEOUT = S_FAULT;
`else
  localparam state_t OPEN_TIMEOUT  = S_OPEN;
  localparam state_t CLOSE_TIMEOUT = S_CLOSED;
`endif

  state_t      state_q, state_d;
  logic        acc_open_q, acc_open_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [15:0] trav_q, trav_d;
  logic        motor_open_q, motor_open_d;
  logic        motor_close_q, motor_close_d;
  logic        is_open_q, is_open_d;
  logic        is_closed_q, is_closed_d;
  logic        fault_q, fault_d;

  logic req_open;
  logic timeout;
  logic both_limits;
  logic in_stroke;

  always_comb begin
    req_open    = (valve_code == 4'b1110);
    timeout     = (trav_q == TRAVEL_LAST);
    both_limits = limit_open & limit_closed;
    in_stroke   = (state_q == S_OPENING) || (state_q == S_CLOSING);

    // Accepted request only moves after a full run of disagreeing samples.
    acc_open_d = acc_open_q;
    stab_cnt_d = 8'd0;
    if (req_open != acc_open_q) begin
      if (stab_cnt_q >= STABLE_LAST) begin
        acc_open_d = req_open;
      end else begin
        stab_cnt_d = stab_cnt_q + 8'd1;
      end
    end

    state_d = state_q;
    if (state_q != S_INIT && both_limits) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_INIT:    state_d = S_CLOSING;
        S_CLOSING: begin
          if (limit_closed)    state_d = S_CLOSED;
          else if (acc_open_q) state_d = S_DEAD;
          else if (timeout)    state_d = CLOSE_TIMEOUT;
        end
        S_OPENING: begin
          if (limit_open)       state_d = S_OPEN;
          else if (!acc_open_q) state_d = S_DEAD;
          else if (timeout)     state_d = OPEN_TIMEOUT;
        end
        S_CLOSED: begin
          if (!limit_closed)   state_d = S_CLOSING;
          else if (acc_open_q) state_d = S_OPENING;
        end
        S_OPEN: begin
          if (!limit_open || !acc_open_q) state_d = S_CLOSING;
        end
        S_DEAD:  state_d = acc_open_q ? S_OPENING : S_CLOSING;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_INIT;
      endcase
    end

    trav_d = 16'd0;
    if ((state_d == S_OPENING || state_d == S_CLOSING) && state_d != state_q) begin
      trav_d = 16'd0;
    end else if (in_stroke) begin
      trav_d = (trav_q >= TRAVEL_MAX) ? TRAVEL_MAX : trav_q + 16'd1;
    end

    // Outputs are registered copies of the next state's decode.
    motor_open_d  = (state_d == S_OPENING);
    motor_close_d = (state_d == S_CLOSING);
    is_open_d     = (state_d == S_OPEN);
    is_closed_d   = (state_d == S_CLOSED);
    fault_d       = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      acc_open_q    <= 1'b0;
      stab_cnt_q    <= 8'd0;
      trav_q        <= 16'd0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      is_open_q     <= 1'b0;
      is_closed_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_open_q    <= acc_open_d;
      stab_cnt_q    <= stab_cnt_d;
      trav_q        <= trav_d;
      motor_open_q  <= motor_open_d;
      motor_close_q <= motor_close_d;
      is_open_q     <= is_open_d;
      is_closed_q   <= is_closed_d;
      fault_q       <= fault_d;
    end
  end

  assign motor_open      = motor_open_q;
  assign motor_close     = motor_close_q;
  assign valve_is_open   = is_open_q;
  assign valve_is_closed = is_closed_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_water_valve_actuator.sv
// tb/tb_water_valve_actuator.sv - directed vector table plus corner sequences for water_valve_actuator
module tb_water_valve_actuator;

  logic       clk;
  logic       rst_n;
  logic [3:0] valve_code;
  logic       limit_open;
  logic       limit_closed;
  logic       motor_open;
  logic       motor_close;
  logic       valve_is_open;
  logic       valve_is_closed;
  logic       fault;
  logic [4:0] outs;

  int checks;
  int failures;

  // Output vector order: {motor_open, motor_close, valve_is_open, valve_is_closed, fault}
  localparam logic [4:0] O_IDLE    = 5'b00000;
  localparam logic [4:0] O_OPENING = 5'b10000;
  localparam logic [4:0] O_CLOSING = 5'b01000;
  localparam logic [4:0] O_OPEN    = 5'b00100;
  localparam logic [4:0] O_CLOSED  = 5'b00010;
  localparam logic [4:0] O_FAULT   = 5'b00001;

`ifdef WATER_VALVE_TIMEOUT_FAULT_EN
  localparam logic [4:0] O_OPEN_TO  = O_FAULT;
  localparam logic [4:0] O_CLOSE_TO = O_FAULT;
`else
  localparam logic [4:0] O_OPEN_TO  = O_OPEN;
  localparam logic [4:0] O_CLOSE_TO = O_CLOSED;
`endif

  typedef struct {
    logic [3:0] code;
    logic       lo;
    logic       lc;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  water_valve_actuator #(
    .STABLE_CYCLES(4),
    .TRAVEL_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valve_code     (valve_code),
    .limit_open     (limit_open),
    .limit_closed   (limit_closed),
    .motor_open     (motor_open),
    .motor_close    (motor_close),
    .valve_is_open  (valve_is_open),
    .valve_is_closed(valve_is_closed),
    .fault          (fault)
  );

  assign outs = {motor_open, motor_close, valve_is_open, valve_is_closed, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic [3:0] code, input logic lo, input logic lc,
                              input logic [4:0] exp, input int n);
    vec_t v;
    v.code = code;
    v.lo   = lo;
    v.lc   = lc;
    v.exp  = exp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input logic [3:0] code, input logic lo, input logic lc);
    rst_n        = 1'b0;
    valve_code   = code;
    limit_open   = lo;
    limit_closed = lc;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until(input string name, input logic [4:0] exp, input int max_cycles);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max_cycles && !hit; i++) begin
      step();
      if (outs === exp) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL %s: timed out after %0d cycles, got %b expected %b", name, max_cycles, outs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset, closing stroke, filter pulse, opening, mid-stroke reversal, timed close.
    add(4'b1111, 1'b0, 1'b0, O_CLOSING, 3);
    add(4'b1111, 1'b0, 1'b1, O_CLOSED,  1);
    add(4'b1110, 1'b0, 1'b1, O_CLOSED,  3);
    add(4'b1111, 1'b0, 1'b1, O_CLOSED,  2);
    add(4'b1110, 1'b0, 1'b1, O_CLOSED,  4);
    add(4'b1110, 1'b0, 1'b1, O_OPENING, 1);
    add(4'b1110, 1'b0, 1'b0, O_OPENING, 7);
    add(4'b0000, 1'b0, 1'b0, O_OPENING, 4);
    add(4'b0000, 1'b0, 1'b0, O_IDLE,    1);
    add(4'b0000, 1'b0, 1'b0, O_CLOSING, 16);
    add(4'b0000, 1'b0, 1'b0, O_CLOSE_TO, 1);

    rst_n        = 1'b0;
    valve_code   = 4'b1111;
    limit_open   = 1'b0;
    limit_closed = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, O_IDLE);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      valve_code   = vecs[i].code;
      limit_open   = vecs[i].lo;
      limit_closed = vecs[i].lc;
      step();
      chk($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // Both limits while open -> sticky fault, cleared only by async reset.
    start(4'b1110, 1'b0, 1'b1);
    run_until("reach_opening", O_OPENING, 20);
    limit_closed = 1'b0;
    limit_open   = 1'b1;
    step();
    chk("reach_open", outs, O_OPEN);
    limit_closed = 1'b1;
    step();
    chk("both_limits_fault", outs, O_FAULT);
    limit_open   = 1'b0;
    limit_closed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valve_code = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      step();
      chk($sformatf("fault_sticky%0d", i), outs, O_FAULT);
    end
    #2 rst_n = 1'b0;
    #1 chk("fault_async_clear", outs, O_IDLE);

    // Reset mid-stroke drops the motor before the next clock edge.
    start(4'b1111, 1'b0, 1'b0);
    step();
    chk("closing_before_reset", outs, O_CLOSING);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_motor", outs, O_IDLE);

    // Opening stroke without limit_open runs exactly TRAVEL_CYCLES cycles.
    start(4'b1110, 1'b0, 1'b1);
    run_until("timeout_opening", O_OPENING, 20);
    limit_closed = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("opening_cycle%0d", i), outs, O_OPENING);
    end
    step();
    chk("open_timeout", outs, O_OPEN_TO);

    // Random stimulus: motors never driven in both directions at once.
    start(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       valve_code = 4'b1110;
        1:       valve_code = 4'b1111;
        default: valve_code = 4'($urandom_range(0, 15));
      endcase
      limit_open   = ($urandom_range(0, 3) == 0);
      limit_closed = limit_open ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
      chk($sformatf("motor_exclusive%0d", i), {3'b000, motor_open & motor_close, 1'b0}, 5'b00000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/water_valve_actuator.md
WATER_VALVE_ACTUATOR -- requirements
Module: water_valve_actuator

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive cycles valve_code must hold before it is accepted (range 1..255).
REQ-002 Parameter TRAVEL_CYCLES, default 1000: maximum motor-on cycles for one open or close stroke (range 2..65535).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 valve_code  input  4  valve command from the supply controller: 4'b1110 = open, 4'b1111 = close, any other value invalid.
REQ-006 limit_open  input  1  end-stop sensor, valve fully open.
REQ-007 limit_closed  input  1  end-stop sensor, valve fully closed.
REQ-008 motor_open  output  1  drives the valve toward open.
REQ-009 motor_close  output  1  drives the valve toward closed.
REQ-010 valve_is_open  output  1  valve confirmed open.
REQ-011 valve_is_closed  output  1  valve confirmed closed.
REQ-012 fault  output  1  sticky fault; cleared only by reset.

Function
REQ-013 Code decode: 4'b1110 -> request OPEN; 4'b1111 and every invalid code -> request CLOSE (fail-safe).
REQ-014 Stability filter: the accepted request changes only after the decoded request differs from the accepted one for STABLE_CYCLES consecutive rising edges; any interruption restarts the count.
REQ-015 States: INIT, CLOSING, CLOSED, OPENING, OPEN, DEAD, FAULT; registered, one-hot or binary at implementer's choice.
REQ-016 Outputs decode from state only: motor_open=1 only in OPENING; motor_close=1 only in CLOSING; valve_is_open=1 only in OPEN; valve_is_closed=1 only in CLOSED; fault=1 only in FAULT.
REQ-017 motor_open and motor_close are never both 1 in any cycle.
REQ-018 INIT -> CLOSING on the first rising edge after reset release, regardless of valve_code.
REQ-019 CLOSING -> CLOSED when limit_closed=1; OPENING -> OPEN when limit_open=1.
REQ-020 CLOSED -> OPENING when accepted request is OPEN; OPEN -> CLOSING when accepted request is CLOSE.
REQ-021 Reversal mid-stroke (accepted request opposes the current OPENING/CLOSING direction) -> DEAD for exactly one cycle, then the new direction with the travel counter cleared.
REQ-022 Travel counter: 16 bits, cleared on entry to OPENING/CLOSING, increments each cycle in them, saturates at TRAVEL_CYCLES.
REQ-023 limit_open=1 and limit_closed=1 together in any state other than INIT -> FAULT on the next edge.
REQ-024 In OPEN, limit_open falling to 0 -> CLOSING; in CLOSED, limit_closed falling to 0 -> CLOSING (valve drift is recovered toward closed).
REQ-025 FAULT is absorbing: all motor outputs 0 until rst_n is asserted.

Reset
REQ-026 While rst_n=0: state=INIT, filter counter=0, accepted request=CLOSE, travel counter=0; all five outputs 0.
REQ-027 Reset asserted mid-stroke drops motor outputs combinationally-independent of clk (asynchronous), within the same cycle.

Configuration
REQ-028 Macro WATER_VALVE_TIMEOUT_FAULT_EN defined: travel counter reaching TRAVEL_CYCLES in OPENING/CLOSING without the matching limit switch -> FAULT.
REQ-029 Macro undefined: the same timeout instead moves OPENING -> OPEN or CLOSING -> CLOSED (timed travel trusted); REQ-023 still applies.

Verification (STABLE_CYCLES=4, TRAVEL_CYCLES=16)
REQ-030 Release reset with valve_code=4'b1111, limit_closed=1 after 3 cycles -> motor_close=1 from cycle 1 to 3, then valve_is_closed=1.
REQ-031 From CLOSED, valve_code=4'b1110 held -> motor_open rises on the 5th edge after change; code pulsed to 4'b1110 for only 3 cycles -> no motor activity.
REQ-032 OPENING at travel count 7, valve_code to 4'b0000 held 4 cycles -> one cycle with both motors 0, then motor_close=1, counter restarts at 0.
REQ-033 Assert limit_open=1 and limit_closed=1 in OPEN -> fault=1 next edge, motors 0, persists until rst_n=0.
REQ-034 OPENING with no limit_open for 16 cycles -> fault=1 with WATER_VALVE_TIMEOUT_FAULT_EN, valve_is_open=1 without it.
REQ-035 Any random stimulus -> assert motor_open and motor_close never both 1.
